// File: rtl/reaction_game_ctrl.sv
// Reaction-time game sequencer: arms on a press, waits a randomized number of ticks,
// counts elapsed tenths in BCD until the player presses, then holds the result.
module reaction_game_ctrl #(
    parameter int MIN_DELAY    = 10,
    parameter int RAND_BITS    = 4,
    parameter int FINISH_TICKS = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       btn,
    input  logic [7:0] rand_in,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic [1:0] state,
    output logic       go,
    output logic       early,
    output logic       timeout
);

    typedef enum logic [1:0] {
        START  = 2'd0,
        READY  = 2'd1,
        PLAY   = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [3:0] BLANK = 4'hF;

    state_t     cur_state, nxt_state;
    logic [7:0] delay, delay_nxt;
    logic [7:0] fin_cnt, fin_nxt;
    logic [7:0] load_delay;
    logic [3:0] tens_nxt, ones_nxt;
    logic       early_nxt, timeout_nxt;
    logic       btn_q;
    logic       press;
    logic       unused_rand;

    assign state       = cur_state;
    assign press       = btn & ~btn_q;
    assign load_delay  = 8'(MIN_DELAY) + 8'(rand_in[RAND_BITS-1:0]);
    assign unused_rand = ^rand_in[7:RAND_BITS];

    // Press always takes priority over a coincident tick in every state.
    always_comb begin
        nxt_state   = cur_state;
        delay_nxt   = delay;
        fin_nxt     = fin_cnt;
        tens_nxt    = tens;
        ones_nxt    = ones;
        early_nxt   = early;
        timeout_nxt = timeout;

        case (cur_state)
            START: begin
                tens_nxt    = BLANK;
                ones_nxt    = BLANK;
                early_nxt   = 1'b0;
                timeout_nxt = 1'b0;
                if (press) begin
                    nxt_state = READY;
                    delay_nxt = load_delay;
                end
            end

            READY: begin
                if (press) begin
                    nxt_state = FINISH;
                    early_nxt = 1'b1;
                    fin_nxt   = 8'd0;
                end else if (tick) begin
                    if (delay == 8'd1) begin
                        nxt_state = PLAY;
                        tens_nxt  = 4'd0;
                        ones_nxt  = 4'd0;
                    end else begin
                        delay_nxt = delay - 8'd1;
                    end
                end
            end

            PLAY: begin
                if (press) begin
                    nxt_state = FINISH;
                    fin_nxt   = 8'd0;
                end else if (tick) begin
                    if (tens == 4'd9 && ones == 4'd9) begin
                        nxt_state   = FINISH;
                        timeout_nxt = 1'b1;
                        fin_nxt     = 8'd0;
                    end else if (ones == 4'd9) begin
                        ones_nxt = 4'd0;
                        tens_nxt = tens + 4'd1;
                    end else begin
                        ones_nxt = ones + 4'd1;
                    end
                end
            end

            FINISH: begin
                if (press || (tick && (fin_cnt + 8'd1 == 8'(FINISH_TICKS)))) begin
                    nxt_state   = START;
                    tens_nxt    = BLANK;
                    ones_nxt    = BLANK;
                    early_nxt   = 1'b0;
                    timeout_nxt = 1'b0;
                end else if (tick) begin
                    fin_nxt = fin_cnt + 8'd1;
                end
            end

            default: nxt_state = START;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_state <= START;
            delay     <= 8'd0;
            fin_cnt   <= 8'd0;
            tens      <= BLANK;
            ones      <= BLANK;
            early     <= 1'b0;
            timeout   <= 1'b0;
            go        <= 1'b0;
            btn_q     <= 1'b1;
        end else begin
            cur_state <= nxt_state;
            delay     <= delay_nxt;
            fin_cnt   <= fin_nxt;
            tens      <= tens_nxt;
            ones      <= ones_nxt;
            early     <= early_nxt;
            timeout   <= timeout_nxt;
            go        <= (nxt_state == PLAY);
            btn_q     <= btn;
        end
    end

endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Directed self-checking bench for reaction_game_ctrl; observations pack
// {state, tens, ones, go, early, timeout} into one vector per check.
module tb_reaction_game_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic       btn;
    logic [7:0] rand_in;
    logic [3:0] tens, ones;
    logic [1:0] state;
    logic       go, early, timeout;

    logic [12:0] obs;
    logic [12:0] exp_v;
    int          checks = 0;
    int          passes = 0;

    reaction_game_ctrl #(
        .MIN_DELAY   (10),
        .RAND_BITS   (4),
        .FINISH_TICKS(50)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick   (tick),
        .btn    (btn),
        .rand_in(rand_in),
        .tens   (tens),
        .ones   (ones),
        .state  (state),
        .go     (go),
        .early  (early),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    assign obs = {state, tens, ones, go, early, timeout};

    // One clock with the given inputs; outputs are stable 1 ns after the edge.
    task automatic step(input logic t, input logic b);
        tick = t;
        btn  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        exp_v = {2'd0, 4'hF, 4'hF, 3'b000};
        checks++;
        if (obs !== exp_v) $display("[TB] FAIL reset_state: got %h expected %h", obs, exp_v);
        else passes++;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
        checks++;
        if (obs !== exp_v) $display("[TB] FAIL held_btn_no_press: got %h expected %h", obs, exp_v);
        else passes++;
        step(1'b0, 1'b0);
    endtask

    task automatic test_arm_and_play;
        rand_in = 8'h03;
        step(1'b0, 1'b1);
        rand_in = 8'hFF;
        exp_v = {2'd1, 4'hF, 4'hF, 3'b000};
        checks++;
        if (obs !== exp_v) $display("[TB] FAIL arm_ready: got %h expected %h", obs, exp_v);
        else passes++;
        step(1'b0, 1'b0);
        tick_n(12);
        checks++;
        if (obs !== exp_v) $display("[TB] FAIL ready_after_12: got %h expected %h", obs, exp_v);
        else passes++;
        step(1'b1, 1'b0);
        exp_v = {2'd2, 4'd0, 4'd0, 3'b100};
        checks++;
        if (obs !== exp_v) $display("[TB] FAIL play_on_13th: got %h expected %h", obs, exp_v);
        else passes++;
        step(1'b0, 1'b0);
    endtask

    task automatic test_play_press;
        tick_n(37);
        exp_v = {2'd2, 4'd3, 4'd7, 3'b100};
        checks++;
        if (obs !== exp_v) $display("[TB] FAIL count_37: got %h expected %h", obs, exp_v);
        else passes++;
        step(1'b0, 1'b1);
        exp_v = {2'd3, 4'd3, 4'd7, 3'b000};
        checks++;
        if (obs !== exp_v) $display("[TB] FAIL finish_37: got %h expected %h", obs, exp_v);
        else passes++;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1);
            step(1'b0, 1'b1);
        end
        checks++;
        if (obs !== exp_v) $display("[TB] FAIL finish_hold_37: got %h expected %h", obs, exp_v);
        else passes++;
        step(1'b0, 1'b0);
    endtask

    task automatic test_finish_return;
        tick_n(46);
        exp_v = {2'd3, 4'd3, 4'd7, 3'b000};
        checks++;
        if (obs !== exp_v) $display("[TB] FAIL finish_tick_49: got %h expected %h", obs, exp_v);
        else passes++;
        step(1'b1, 1'b0);
        exp_v = {2'd0, 4'hF, 4'hF, 3'b000};
        checks++;
        if (obs !== exp_v) $display("[TB] FAIL finish_tick_50: got %h expected %h", obs, exp_v);
        else passes++;
        step(1'b0, 1'b0);
    endtask

    task automatic test_false_start;
        rand_in = 8'h00;
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        tick_n(4);
        step(1'b1, 1'b1);
        exp_v = {2'd3, 4'hF, 4'hF, 3'b010};
        checks++;
        if (obs !== exp_v) $display("[TB] FAIL false_start: got %h expected %h", obs, exp_v);
        else passes++;
        step(1'b0, 1'b0);
        tick_n(3);
        checks++;
        if (obs !== exp_v) $display("[TB] FAIL false_start_hold: got %h expected %h", obs, exp_v);
        else passes++;
        step(1'b0, 1'b1);
        exp_v = {2'd0, 4'hF, 4'hF, 3'b000};
        checks++;
        if (obs !== exp_v) $display("[TB] FAIL finish_press_start: got %h expected %h", obs, exp_v);
        else passes++;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        checks++;
        if (obs !== exp_v) $display("[TB] FAIL held_no_rearm: got %h expected %h", obs, exp_v);
        else passes++;
        step(1'b0, 1'b0);
    endtask

    task automatic test_timeout;
        rand_in = 8'hF1;
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        tick_n(10);
        exp_v = {2'd1, 4'hF, 4'hF, 3'b000};
        checks++;
        if (obs !== exp_v) $display("[TB] FAIL masked_delay_ready: got %h expected %h", obs, exp_v);
        else passes++;
        step(1'b1, 1'b0);
        exp_v = {2'd2, 4'd0, 4'd0, 3'b100};
        checks++;
        if (obs !== exp_v) $display("[TB] FAIL masked_delay_play: got %h expected %h", obs, exp_v);
        else passes++;
        step(1'b0, 1'b0);
        tick_n(99);
        exp_v = {2'd2, 4'd9, 4'd9, 3'b100};
        checks++;
        if (obs !== exp_v) $display("[TB] FAIL count_99: got %h expected %h", obs, exp_v);
        else passes++;
        step(1'b1, 1'b0);
        exp_v = {2'd3, 4'd9, 4'd9, 3'b001};
        checks++;
        if (obs !== exp_v) $display("[TB] FAIL timeout_100: got %h expected %h", obs, exp_v);
        else passes++;
        step(1'b0, 1'b0);
        tick_n(2);
        checks++;
        if (obs !== exp_v) $display("[TB] FAIL timeout_hold: got %h expected %h", obs, exp_v);
        else passes++;
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_play;
        rand_in = 8'h00;
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        tick_n(10);
        tick_n(42);
        exp_v = {2'd2, 4'd4, 4'd2, 3'b100};
        checks++;
        if (obs !== exp_v) $display("[TB] FAIL count_42: got %h expected %h", obs, exp_v);
        else passes++;
        rst_n = 1'b0;
        step(1'b1, 1'b1);
        exp_v = {2'd0, 4'hF, 4'hF, 3'b000};
        checks++;
        if (obs !== exp_v) $display("[TB] FAIL reset_mid_play: got %h expected %h", obs, exp_v);
        else passes++;
        rst_n = 1'b1;
        step(1'b0, 1'b1);
        checks++;
        if (obs !== exp_v) $display("[TB] FAIL reset_held_btn: got %h expected %h", obs, exp_v);
        else passes++;
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        exp_v = {2'd1, 4'hF, 4'hF, 3'b000};
        checks++;
        if (obs !== exp_v) $display("[TB] FAIL rearm_after_release: got %h expected %h", obs, exp_v);
        else passes++;
        step(1'b0, 1'b0);
    endtask

    initial begin
        rst_n   = 1'b0;
        tick    = 1'b0;
        btn     = 1'b1;
        rand_in = 8'h00;
        test_reset;
        test_arm_and_play;
        test_play_press;
        test_finish_return;
        test_false_start;
        test_timeout;
        test_reset_mid_play;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
